swd_if: RTL and testbench

- SWD (Serial Wire Debug) host-side PHY/link engine.
- Converts one parallel DP/AP register access request into the serial SWD wire sequence: request, turnaround, ACK, data, parity.
- Returns the ACK, read data and parity status to the upstream command controller.
- Sits between the debug command controller and the SWDIO/SWCLK pad logic.

---
 rtl/swd_pkg.sv | 30 +++
 rtl/swd_clkgen.sv | 38 +++
 rtl/swd_if.sv | 215 +++++++++++++++++++++
 tb/tb_swd_if.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/swd_pkg.sv
// Shared definitions for the SWD host link engine: ACK codes, FSM states and
// the 8-bit request header builder.
package swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        TRN1,
        ACK,
        RDATA,
        RPAR,
        TRN2,
        WDATA,
        WPAR,
        DONE
    } swd_state_t;

    // Bit i of the result is the i-th bit sent on the wire.
    function automatic logic [7:0] swd_req_bits(input logic       apndp,
                                                input logic       rnw,
                                                input logic [1:0] addr32);
        return {1'b1, 1'b0, apndp ^ rnw ^ addr32[0] ^ addr32[1],
                addr32[1], addr32[0], rnw, apndp, 1'b1};
    endfunction

endpackage

// File: rtl/swd_clkgen.sv
// SWCLK generator: low phase then high phase of clkDiv clk cycles each,
// with single-cycle strobes in the last cycle of each phase.
module swd_clkgen (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] clkDiv,
    input  logic        enable,
    output logic        swclk,
    output logic        rise_stb,
    output logic        fall_stb
);

    logic [10:0] cnt_reg;
    logic        swclk_reg;
    logic [10:0] half_len;
    logic        phase_end;

    assign half_len  = (clkDiv == 11'd0) ? 11'd1 : clkDiv;
    // ">=" keeps a mid-transaction shrink of clkDiv from stalling the counter.
    assign phase_end = enable && (cnt_reg >= half_len - 11'd1);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt_reg   <= 11'd0;
            swclk_reg <= 1'b0;
        end else if (phase_end) begin
            cnt_reg   <= 11'd0;
            swclk_reg <= ~swclk_reg;
        end else begin
            cnt_reg   <= cnt_reg + 11'd1;
        end
    end

    assign swclk    = swclk_reg;
    assign rise_stb = phase_end && !swclk_reg;
    assign fall_stb = phase_end && swclk_reg;

endmodule

// File: rtl/swd_if.sv
// SWD host link engine: serialises one DP/AP access into request, turnaround,
// ACK, data and parity bits and returns ACK, read data and parity status.
module swd_if
    import swd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        swdi,
    output logic        swdo,
    output logic        swwr,
    output logic        swclk,
    input  logic [10:0] clkDiv,
    input  logic [1:0]  addr32,
    input  logic        rnw,
    input  logic        apndp,
    input  logic [31:0] din,
    output logic [2:0]  ack,
    output logic [31:0] dout,
    output logic        err,
    input  logic        go,
    output logic        done
);

    swd_state_t  state_reg, state_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  req_reg, req_next;
    logic        rnw_reg, rnw_next;
    logic [31:0] din_reg, din_next;
    logic [2:0]  ack_reg, ack_next;
    logic [31:0] rdata_reg, rdata_next;
    logic [31:0] dout_reg, dout_next;
    logic        err_reg, err_next;
    logic        swdo_reg, swdo_next;
    logic        swwr_reg, swwr_next;
    logic        done_reg, done_next;

    logic        clk_en;
    logic        rise_stb;
    logic        fall_stb;
    logic [7:0]  req_new;

    assign clk_en  = (state_reg != IDLE) && (state_reg != DONE);
    assign req_new = swd_req_bits(apndp, rnw, addr32);

    swd_clkgen u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .clkDiv   (clkDiv),
        .enable   (clk_en),
        .swclk    (swclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 5'd0;
            req_reg     <= 8'd0;
            rnw_reg     <= 1'b0;
            din_reg     <= 32'd0;
            ack_reg     <= 3'd0;
            rdata_reg   <= 32'd0;
            dout_reg    <= 32'd0;
            err_reg     <= 1'b0;
            swdo_reg    <= 1'b0;
            swwr_reg    <= 1'b1;
            done_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            req_reg     <= req_next;
            rnw_reg     <= rnw_next;
            din_reg     <= din_next;
            ack_reg     <= ack_next;
            rdata_reg   <= rdata_next;
            dout_reg    <= dout_next;
            err_reg     <= err_next;
            swdo_reg    <= swdo_next;
            swwr_reg    <= swwr_next;
            done_reg    <= done_next;
        end
    end

    // swdo/swwr are computed for the bit that begins on the falling strobe,
    // so they change together with swclk going low.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        req_next     = req_reg;
        rnw_next     = rnw_reg;
        din_next     = din_reg;
        ack_next     = ack_reg;
        rdata_next   = rdata_reg;
        dout_next    = dout_reg;
        err_next     = err_reg;
        swdo_next    = swdo_reg;
        swwr_next    = swwr_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (go) begin
                    state_next   = REQ;
                    bit_cnt_next = 5'd0;
                    req_next     = req_new;
                    rnw_next     = rnw;
                    din_next     = din;
                    err_next     = 1'b0;
                    swdo_next    = req_new[0];
                    swwr_next    = 1'b1;
                end else begin
                    state_next   = IDLE;
                end
            end
            REQ: begin
                if (fall_stb) begin
                    if (bit_cnt_reg == 5'd7) begin
                        state_next   = TRN1;
                        swwr_next    = 1'b0;
                        swdo_next    = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        swdo_next    = req_reg[bit_cnt_reg[2:0] + 3'd1];
                    end
                end
            end
            TRN1: begin
                if (fall_stb) begin
                    state_next   = ACK;
                    bit_cnt_next = 5'd0;
                end
            end
            ACK: begin
                if (rise_stb) begin
                    ack_next = {swdi, ack_reg[2:1]};
                end
                if (fall_stb) begin
                    if (bit_cnt_reg == 5'd2) begin
                        bit_cnt_next = 5'd0;
                        state_next   = (ack_reg == ACK_OK && rnw_reg) ? RDATA : TRN2;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            RDATA: begin
                if (rise_stb) begin
                    rdata_next = {swdi, rdata_reg[31:1]};
                end
                if (fall_stb) begin
                    if (bit_cnt_reg == 5'd31) begin
                        state_next   = RPAR;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                    end
                end
            end
            RPAR: begin
                if (rise_stb) begin
                    dout_next = rdata_reg;
                    err_next  = (^rdata_reg) ^ swdi;
                end
                if (fall_stb) begin
                    state_next = TRN2;
                end
            end
            TRN2: begin
                if (fall_stb) begin
                    swwr_next = 1'b1;
                    if (ack_reg == ACK_OK && !rnw_reg) begin
                        state_next   = WDATA;
                        bit_cnt_next = 5'd0;
                        swdo_next    = din_reg[0];
                    end else begin
                        state_next   = DONE;
                        swdo_next    = 1'b0;
                    end
                end
            end
            WDATA: begin
                if (fall_stb) begin
                    if (bit_cnt_reg == 5'd31) begin
                        state_next   = WPAR;
                        swdo_next    = ^din_reg;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        swdo_next    = din_reg[bit_cnt_reg + 5'd1];
                    end
                end
            end
            WPAR: begin
                if (fall_stb) begin
                    state_next = DONE;
                    swwr_next  = 1'b1;
                    swdo_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                swwr_next  = 1'b1;
                swdo_next  = 1'b0;
            end
        endcase

        done_next = (state_next == IDLE) || (state_next == DONE);
    end

    assign swdo = swdo_reg;
    assign swwr = swwr_reg;
    assign ack  = ack_reg;
    assign dout = dout_reg;
    assign err  = err_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_swd_if.sv
// Bench for swd_if: a wire-level target model answers each access while a
// scoreboard holds the expected ACK/data/err and wire pattern per transaction.
module tb_swd_if;
    import swd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        swdi;
    logic        swdo;
    logic        swwr;
    logic        swclk;
    logic [10:0] clkDiv;
    logic [1:0]  addr32;
    logic        rnw;
    logic        apndp;
    logic [31:0] din;
    logic [2:0]  ack;
    logic [31:0] dout;
    logic        err;
    logic        go;
    logic        done;

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] dout;
        logic        err;
        int          nbits;
        logic [7:0]  req;
        logic [63:0] swwr_mask;
        logic        is_wr_ok;
        logic [32:0] wbits;
        int          half;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_dout = 32'd0;

    // Target model state and wire log, indexed by bit number of the transaction.
    logic        resp_bits [0:63];
    logic        swdo_log  [0:63];
    logic        swwr_log  [0:63];
    int          bit_idx    = 0;
    logic        prev_swclk = 1'b0;
    logic        prev_done  = 1'b1;
    int          run  = 0;
    int          lo0  = 0;
    int          hi0  = 0;
    int          busy = 0;

    always #5 clk = ~clk;

    swd_if dut (
        .clk    (clk),
        .rst    (rst),
        .swdi   (swdi),
        .swdo   (swdo),
        .swwr   (swwr),
        .swclk  (swclk),
        .clkDiv (clkDiv),
        .addr32 (addr32),
        .rnw    (rnw),
        .apndp  (apndp),
        .din    (din),
        .ack    (ack),
        .dout   (dout),
        .err    (err),
        .go     (go),
        .done   (done)
    );

    // Target presents bit n until swclk has risen for bit n, then moves on.
    assign swdi = resp_bits[bit_idx[5:0]];

    always @(negedge clk) begin
        prev_swclk <= swclk;
        prev_done  <= done;
        if (!done && prev_done) begin
            bit_idx <= 0;
            run     <= 1;
            busy    <= 1;
        end else if (!done) begin
            busy <= busy + 1;
            if (swclk != prev_swclk) begin
                run <= 1;
                if (swclk) begin
                    swdo_log[bit_idx[5:0]] <= swdo;
                    swwr_log[bit_idx[5:0]] <= swwr;
                    bit_idx <= bit_idx + 1;
                    if (bit_idx == 0) lo0 <= run;
                end else if (bit_idx == 1) begin
                    hi0 <= run;
                end
            end else begin
                run <= run + 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_target(input logic [2:0] rack, input logic [31:0] rdat, input logic rpar);
        for (int i = 0; i < 64; i++) resp_bits[i] = 1'b0;
        for (int i = 0; i < 3; i++) resp_bits[9 + i] = rack[i];
        for (int i = 0; i < 32; i++) resp_bits[12 + i] = rdat[i];
        resp_bits[44] = rpar;
    endtask

    task automatic compare_result(input string tag);
        exp_t        e;
        logic [7:0]  got_req;
        logic [63:0] got_mask;
        logic [32:0] got_w;
        if (sb_q.size() == 0) begin
            check_val({tag, " sb_nonempty"}, 64'(0), 64'(1));
            return;
        end
        e = sb_q.pop_front();
        got_mask = 64'd0;
        for (int i = 0; i < 8; i++) got_req[i] = swdo_log[i];
        for (int i = 0; i < e.nbits; i++) got_mask[i] = swwr_log[i];
        for (int i = 0; i < 33; i++) got_w[i] = swdo_log[13 + i];
        check_val({tag, " ack"}, 64'(ack), 64'(e.ack));
        check_val({tag, " dout"}, 64'(dout), 64'(e.dout));
        check_val({tag, " err"}, 64'(err), 64'(e.err));
        check_val({tag, " nbits"}, 64'(bit_idx), 64'(e.nbits));
        check_val({tag, " busy_clks"}, 64'(busy), 64'(2 * e.half * e.nbits));
        check_val({tag, " req_bits"}, 64'(got_req), 64'(e.req));
        check_val({tag, " swwr_mask"}, got_mask, e.swwr_mask);
        check_val({tag, " low_len"}, 64'(lo0), 64'(e.half));
        check_val({tag, " high_len"}, 64'(hi0), 64'(e.half));
        if (e.is_wr_ok) check_val({tag, " wdata"}, 64'(got_w), 64'(e.wbits));
        check_val({tag, " idle_pins"}, 64'({swclk, swwr, swdo}), 64'(3'b010));
        $display("txn %s ack=%b dout=%h err=%b bits=%0d", tag, ack, dout, err, bit_idx);
    endtask

    task automatic run_txn(input string tag, input logic ap, input logic rd, input logic [1:0] a,
                           input logic [31:0] wd, input logic [10:0] div,
                           input logic [2:0] rack, input logic [31:0] rdat, input logic rpar);
        exp_t e;
        int   limit;
        logic ok;
        ok       = (rack == ACK_OK);
        e.half   = (div == 11'd0) ? 1 : int'(div);
        e.ack    = rack;
        e.req    = {1'b1, 1'b0, ap ^ rd ^ a[0] ^ a[1], a[1], a[0], rd, ap, 1'b1};
        e.nbits  = ok ? 46 : 13;
        e.swwr_mask = 64'd0;
        for (int i = 0; i < e.nbits; i++) e.swwr_mask[i] = (i < 8) || (!rd && ok && i >= 13);
        e.is_wr_ok = ok && !rd;
        e.wbits    = {^wd, wd};
        if (ok && rd) begin
            model_dout = rdat;
            e.err      = ((^rdat) != rpar);
        end else begin
            e.err      = 1'b0;
        end
        e.dout = model_dout;
        sb_q.push_back(e);

        load_target(rack, rdat, rpar);
        @(negedge clk);
        apndp = ap; rnw = rd; addr32 = a; din = wd; clkDiv = div; go = 1'b1;
        for (int k = 0; k < 10 && done; k++) @(negedge clk);
        check_val({tag, " busy"}, 64'(done), 64'(0));
        go = 1'b0;
        limit = 2 * e.half * 46 + 20;
        for (int k = 0; k < limit && !done; k++) @(negedge clk);
        check_val({tag, " done"}, 64'(done), 64'(1));
        @(negedge clk);
        compare_result(tag);
    endtask

    initial begin
        logic [31:0] rv;
        for (int i = 0; i < 64; i++) resp_bits[i] = 1'b0;
        rst = 1'b1; go = 1'b0; clkDiv = 11'd2; addr32 = 2'd0; rnw = 1'b0; apndp = 1'b0; din = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst done", 64'(done), 64'(1));
        check_val("rst pins", 64'({swclk, swwr, swdo}), 64'(3'b010));
        check_val("rst ack", 64'(ack), 64'(0));
        check_val("rst dout", 64'(dout), 64'(0));
        check_val("rst err", 64'(err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run_txn("ap_rd",      1'b1, 1'b1, 2'b01, 32'd0,        11'd2, ACK_OK,    32'habcdef12, 1'b1);
        run_txn("ap_rd_perr", 1'b1, 1'b1, 2'b01, 32'd0,        11'd2, ACK_OK,    32'habcdef12, 1'b0);
        run_txn("dp_wr",      1'b0, 1'b0, 2'b10, 32'h12345678, 11'd2, ACK_OK,    32'd0,        1'b0);
        run_txn("rd_wait",    1'b1, 1'b1, 2'b11, 32'd0,        11'd2, ACK_WAIT,  32'h5555aaaa, 1'b1);
        run_txn("wr_fault",   1'b0, 1'b0, 2'b00, 32'hdeadbeef, 11'd3, ACK_FAULT, 32'd0,        1'b0);
        run_txn("rd_div0",    1'b0, 1'b1, 2'b00, 32'd0,        11'd0, ACK_OK,    32'h0f0f1234, 1'b1);
        run_txn("rd_div5",    1'b1, 1'b1, 2'b10, 32'd0,        11'd5, ACK_OK,    32'h80000001, 1'b0);
        for (int n = 0; n < 4; n++) begin
            rv = $urandom;
            run_txn($sformatf("rand%0d", n), 1'($urandom), 1'($urandom), 2'($urandom),
                    $urandom, 11'($urandom_range(1, 4)), ACK_OK, rv, 1'($urandom));
        end

        // Reset in the middle of the read data phase.
        load_target(ACK_OK, 32'hc0ffee11, 1'b1);
        @(negedge clk);
        apndp = 1'b1; rnw = 1'b1; addr32 = 2'b00; clkDiv = 11'd2; go = 1'b1;
        for (int k = 0; k < 10 && done; k++) @(negedge clk);
        go = 1'b0;
        for (int k = 0; k < 400 && bit_idx < 20; k++) @(negedge clk);
        check_val("mid_rst reached_data", 64'(bit_idx >= 20), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst done", 64'(done), 64'(1));
        check_val("mid_rst pins", 64'({swclk, swwr, swdo}), 64'(3'b010));
        check_val("mid_rst ack", 64'(ack), 64'(0));
        check_val("mid_rst dout", 64'(dout), 64'(0));
        check_val("mid_rst err", 64'(err), 64'(0));
        model_dout = 32'd0;
        rst = 1'b0;
        @(negedge clk);
        run_txn("post_rst_wr", 1'b1, 1'b0, 2'b11, 32'ha5a5f00f, 11'd2, ACK_OK, 32'd0,        1'b0);
        run_txn("post_rst_rd", 1'b0, 1'b1, 2'b01, 32'd0,        11'd1, ACK_OK, 32'h13572468, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
